// File: rtl/xgriscv_retire_monitor.sv
// xgriscv_retire_monitor: counts retirements of pcW, flags halt or watchdog hang, and keeps a trace of recent PCs.
module xgriscv_retire_monitor #(
  parameter int ADDR_SIZE = 32,
  parameter logic [ADDR_SIZE-1:0] HALT_ADDR = 32'h80000078,
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 32,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [ADDR_SIZE-1:0]           pcW,
  output logic                           done,
  output logic                           hang,
  output logic [CNT_W-1:0]               cycles,
  output logic [CNT_W-1:0]               retired,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [ADDR_SIZE-1:0]           trace_pc,
  output logic [$clog2(TRACE_DEPTH):0]   trace_cnt
);
  localparam int IW = $clog2(TRACE_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE, HANG} state_t;
  state_t state_q, state_d;
  logic [ADDR_SIZE-1:0] prev_pc_q, prev_pc_d;
  logic [CNT_W-1:0] cycles_q, cycles_d, retired_q, retired_d;
  logic [15:0] stall_q, stall_d;
  logic [IW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr;
  logic [IW:0] cnt_q, cnt_d;
  logic [ADDR_SIZE-1:0] mem_q [TRACE_DEPTH];
  logic [ADDR_SIZE-1:0] mem_d [TRACE_DEPTH];
  logic active, retire;
  always_comb begin
    active = state_q == IDLE || state_q == RUN;
    // prev_pc stays 0 throughout IDLE, so the first nonzero pcW always retires
    retire = active && pcW != '0 && pcW != prev_pc_q;
    state_d = state_q;
    prev_pc_d = active ? pcW : prev_pc_q;
    cycles_d = (state_q == RUN || retire) && cycles_q != '1 ? cycles_q + CNT_W'(1) : cycles_q;
    retired_d = retire && retired_q != '1 ? retired_q + CNT_W'(1) : retired_q;
    stall_d = retire ? 16'd0 : state_q == RUN ? stall_q + 16'd1 : stall_q;
    wr_ptr_d = retire ? wr_ptr_q + IW'(1) : wr_ptr_q;
    cnt_d = retire && cnt_q != (IW+1)'(TRACE_DEPTH) ? cnt_q + (IW+1)'(1) : cnt_q;
    mem_d = mem_q;
    if (retire) mem_d[wr_ptr_q] = pcW;
    if (retire && pcW == HALT_ADDR) state_d = DONE;
    else if (retire && state_q == IDLE) state_d = RUN;
    else if (state_q == RUN && stall_d == 16'(TIMEOUT)) state_d = HANG;
  end
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= IDLE;
      prev_pc_q <= '0;
      cycles_q <= '0;
      retired_q <= '0;
      stall_q <= '0;
      wr_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      prev_pc_q <= prev_pc_d;
      cycles_q <= cycles_d;
      retired_q <= retired_d;
      stall_q <= stall_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q <= cnt_d;
    end
  end
  // trace contents are not reset; cnt_q masks stale entries
  always_ff @(posedge clk) mem_q <= mem_d;
  always_comb begin
    rd_ptr = wr_ptr_q - IW'(1) - trace_idx;
    trace_pc = {1'b0, trace_idx} < cnt_q ? mem_q[rd_ptr] : '0;
    done = state_q == DONE;
    hang = state_q == HANG;
    cycles = cycles_q;
    retired = retired_q;
    trace_cnt = cnt_q;
  end
endmodule

// File: tb/tb_xgriscv_retire_monitor.sv
// tb_xgriscv_retire_monitor: directed vector table plus hand-written multi-cycle sequences.
module tb_xgriscv_retire_monitor;
  logic clk = 0, rstn = 1;
  logic [31:0] pcW = 0;
  logic [2:0] trace_idx = 0;
  logic done, hang, done4, hang4;
  logic [31:0] cycles, retired, trace_pc, cycles4, retired4, trace_pc4;
  logic [3:0] trace_cnt, trace_cnt4;
  int pass = 0, total = 0;
  localparam logic [31:0] HALT = 32'h80000078;
  localparam logic [31:0] A0 = 32'h80000100;

  xgriscv_retire_monitor dut (.clk(clk), .rstn(rstn), .pcW(pcW), .done(done), .hang(hang),
    .cycles(cycles), .retired(retired), .trace_idx(trace_idx), .trace_pc(trace_pc), .trace_cnt(trace_cnt));
  xgriscv_retire_monitor #(.TIMEOUT(4)) dut4 (.clk(clk), .rstn(rstn), .pcW(pcW), .done(done4), .hang(hang4),
    .cycles(cycles4), .retired(retired4), .trace_idx(trace_idx), .trace_pc(trace_pc4), .trace_cnt(trace_cnt4));

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst;
    logic [31:0] pc;
    logic d, h;
    logic [31:0] cyc, ret;
    logic [3:0] cnt;
    logic [31:0] t0;
  } vec_t;
  vec_t v [17];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s got %h want %h", n, a, e);
  endtask

  task automatic step(input logic r, input logic [31:0] p);
    rstn = r;
    pcW = p;
    @(posedge clk);
    #1;
  endtask

  task automatic run_program(input string tag);
    step(1, 0);
    for (int i = 0; i < 3; i++) step(0, 0);
    for (int i = 0; i < 31; i++) step(0, 32'h80000000 + 32'(4 * i));
    trace_idx = 0;
    #1;
    chk({tag, " done"}, 64'(done), 1);
    chk({tag, " hang"}, 64'(hang), 0);
    chk({tag, " retired"}, 64'(retired), 31);
    chk({tag, " cycles"}, 64'(cycles), 31);
    chk({tag, " trace_cnt"}, 64'(trace_cnt), 8);
    chk({tag, " trace0"}, 64'(trace_pc), 64'(HALT));
    trace_idx = 7;
    #1;
    chk({tag, " trace7"}, 64'(trace_pc), 64'h8000005C);
    trace_idx = 0;
  endtask

  initial begin
    v[0]  = '{1'b1, 32'h0,        1'b0, 1'b0, 32'd0,  32'd0, 4'd0, 32'h0};
    v[1]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'd0,  32'd0, 4'd0, 32'h0};
    v[2]  = '{1'b0, 32'h80000000, 1'b0, 1'b0, 32'd1,  32'd1, 4'd1, 32'h80000000};
    v[3]  = '{1'b0, 32'h80000000, 1'b0, 1'b0, 32'd2,  32'd1, 4'd1, 32'h80000000};
    v[4]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'd3,  32'd1, 4'd1, 32'h80000000};
    v[5]  = '{1'b0, 32'h80000004, 1'b0, 1'b0, 32'd4,  32'd2, 4'd2, 32'h80000004};
    v[6]  = '{1'b0, 32'h80000004, 1'b0, 1'b0, 32'd5,  32'd2, 4'd2, 32'h80000004};
    v[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'd6,  32'd2, 4'd2, 32'h80000004};
    v[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'd7,  32'd2, 4'd2, 32'h80000004};
    v[9]  = '{1'b0, 32'h80000008, 1'b0, 1'b0, 32'd8,  32'd3, 4'd3, 32'h80000008};
    v[10] = '{1'b0, 32'h80000008, 1'b0, 1'b0, 32'd9,  32'd3, 4'd3, 32'h80000008};
    v[11] = '{1'b0, 32'h80000004, 1'b0, 1'b0, 32'd10, 32'd4, 4'd4, 32'h80000004};
    v[12] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'd11, 32'd4, 4'd4, 32'h80000004};
    v[13] = '{1'b0, 32'h80000004, 1'b0, 1'b0, 32'd12, 32'd5, 4'd5, 32'h80000004};
    v[14] = '{1'b0, HALT,         1'b1, 1'b0, 32'd13, 32'd6, 4'd6, HALT};
    v[15] = '{1'b0, 32'h80000010, 1'b1, 1'b0, 32'd13, 32'd6, 4'd6, HALT};
    v[16] = '{1'b1, 32'h80000010, 1'b0, 1'b0, 32'd0,  32'd0, 4'd0, 32'h0};
    for (int i = 0; i < 17; i++) begin
      step(v[i].rst, v[i].pc);
      chk($sformatf("vec%0d done", i), 64'(done), 64'(v[i].d));
      chk($sformatf("vec%0d hang", i), 64'(hang), 64'(v[i].h));
      chk($sformatf("vec%0d cycles", i), 64'(cycles), 64'(v[i].cyc));
      chk($sformatf("vec%0d retired", i), 64'(retired), 64'(v[i].ret));
      chk($sformatf("vec%0d trace_cnt", i), 64'(trace_cnt), 64'(v[i].cnt));
      chk($sformatf("vec%0d trace0", i), 64'(trace_pc), 64'(v[i].t0));
    end

    run_program("normal");

    step(1, 0);
    step(0, 0);
    for (int i = 0; i < 5; i++) step(0, 32'h80000000 + 32'(4 * i));
    chk("pre-reset retired", 64'(retired), 5);
    step(1, 32'h80000014);
    chk("reset done", 64'(done), 0);
    chk("reset hang", 64'(hang), 0);
    chk("reset cycles", 64'(cycles), 0);
    chk("reset retired", 64'(retired), 0);
    chk("reset trace_cnt", 64'(trace_cnt), 0);
    chk("reset trace0", 64'(trace_pc), 0);
    run_program("replay");

    step(1, 0);
    step(0, 32'h80000000);
    for (int i = 1; i < 64; i++) step(0, 32'h80000000);
    chk("wd hang@63", 64'(hang), 0);
    step(0, 32'h80000000);
    chk("wd hang@64", 64'(hang), 1);
    chk("wd cycles", 64'(cycles), 65);
    chk("wd retired", 64'(retired), 1);
    step(0, HALT);
    step(0, HALT);
    chk("wd halt ignored", 64'(done), 0);
    chk("wd hang sticky", 64'(hang), 1);
    chk("wd cycles frozen", 64'(cycles), 65);
    chk("wd retired frozen", 64'(retired), 1);
    chk("wd trace_cnt frozen", 64'(trace_cnt), 1);

    step(1, 0);
    step(0, A0);
    for (int i = 0; i < 3; i++) step(0, A0);
    chk("race hang pre", 64'(hang4), 0);
    step(0, HALT);
    chk("race done", 64'(done4), 1);
    chk("race hang", 64'(hang4), 0);
    chk("race retired", 64'(retired4), 2);
    step(1, 0);
    step(0, A0);
    for (int i = 0; i < 3; i++) step(0, A0);
    chk("t4 hang@3", 64'(hang4), 0);
    step(0, 0);
    chk("t4 hang@4", 64'(hang4), 1);
    chk("t4 done", 64'(done4), 0);

    step(1, 0);
    for (int i = 0; i < 3; i++) step(0, A0 + 32'(4 * i));
    chk("tr3 cnt", 64'(trace_cnt), 3);
    trace_idx = 5;
    #1;
    chk("tr3 idx5", 64'(trace_pc), 0);
    trace_idx = 2;
    #1;
    chk("tr3 idx2", 64'(trace_pc), 64'(A0));
    step(1, 0);
    for (int i = 0; i < 10; i++) step(0, A0 + 32'(4 * i));
    chk("wrap cnt", 64'(trace_cnt), 8);
    trace_idx = 0;
    #1;
    chk("wrap idx0", 64'(trace_pc), 64'(A0 + 32'd36));
    trace_idx = 7;
    #1;
    chk("wrap idx7", 64'(trace_pc), 64'(A0 + 32'd8));
    trace_idx = 3;
    #1;
    chk("wrap idx3", 64'(trace_pc), 64'(A0 + 32'd24));

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
